// File: rtl/hex_display_link_receiver.sv
// Far-end receiver for the labkit dot-matrix display link: oversamples the six serial
// display lines in the 27 MHz domain and rebuilds the latched dot and control registers.
module hex_display_link_receiver #(
    parameter int NUM_CHARS     = 16,
    parameter int DOTS_PER_CHAR = 40,
    parameter int CTRL_BITS     = 32
) (
    input  logic                         clock_27mhz,
    input  logic                         reset,
    input  logic                         disp_clock,
    input  logic                         disp_data_out,
    input  logic                         disp_rs,
    input  logic                         disp_ce_b,
    input  logic                         disp_reset_b,
    input  logic                         disp_blank,
    input  logic [$clog2(NUM_CHARS)-1:0] rd_char,
    output logic [DOTS_PER_CHAR-1:0]     rd_dots,
    output logic [CTRL_BITS-1:0]         control_word,
    output logic                         dot_strobe,
    output logic                         ctrl_strobe,
    output logic [9:0]                   last_count,
    output logic                         len_err,
    output logic                         blanked,
    output logic [1:0]                   dbg_state
);

    localparam int DOT_BITS = NUM_CHARS * DOTS_PER_CHAR;
    localparam logic [9:0] CNT_MAX  = 10'h3FF;
    localparam logic [9:0] DOT_LEN  = 10'(DOT_BITS);
    localparam logic [9:0] CTRL_LEN = 10'(CTRL_BITS);

    localparam int S_CLK   = 0;
    localparam int S_DATA  = 1;
    localparam int S_RS    = 2;
    localparam int S_CE    = 3;
    localparam int S_RSTB  = 4;
    localparam int S_BLANK = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DEVRST = 2'd2
    } state_t;

    logic [5:0]               sync1_q;
    logic [5:0]               sync2_q;
    logic                     clk_hist_q;
    logic                     ce_hist_q;

    state_t                   state_q;
    logic                     sel_rs_q;
    logic [9:0]               cnt_q;
    logic [9:0]               cnt_d;
    logic [DOT_BITS-1:0]      dot_sr_q;
    logic [DOT_BITS-1:0]      dot_sr_d;
    logic [CTRL_BITS-1:0]     ctrl_sr_q;
    logic [CTRL_BITS-1:0]     ctrl_sr_d;
    logic [DOT_BITS-1:0]      dot_reg_q;
    logic [CTRL_BITS-1:0]     control_word_q;
    logic                     dot_strobe_q;
    logic                     ctrl_strobe_q;
    logic [9:0]               last_count_q;
    logic                     len_err_q;
    logic [DOTS_PER_CHAR-1:0] rd_dots_q;

    logic clk_rise;
    logic ce_fall;
    logic ce_rise;
    logic shift_en;

    always_ff @(posedge clock_27mhz) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            clk_hist_q <= 1'b0;
            ce_hist_q  <= 1'b0;
        end else begin
            sync1_q    <= {disp_blank, disp_reset_b, disp_ce_b, disp_rs, disp_data_out, disp_clock};
            sync2_q    <= sync1_q;
            clk_hist_q <= sync2_q[S_CLK];
            ce_hist_q  <= sync2_q[S_CE];
        end
    end

    assign clk_rise = sync2_q[S_CLK] & ~clk_hist_q;
    assign ce_fall  = ~sync2_q[S_CE] & ce_hist_q;
    assign ce_rise  = sync2_q[S_CE] & ~ce_hist_q;

    // A clock rise coinciding with the CE rise still shifts, so the latch sees that bit.
    assign shift_en = (state_q == ST_SHIFT) && clk_rise;

    always_comb begin
        dot_sr_d  = dot_sr_q;
        ctrl_sr_d = ctrl_sr_q;
        cnt_d     = cnt_q;
        if (shift_en) begin
            if (sel_rs_q) begin
                ctrl_sr_d = {ctrl_sr_q[CTRL_BITS-2:0], sync2_q[S_DATA]};
            end else begin
                dot_sr_d = {dot_sr_q[DOT_BITS-2:0], sync2_q[S_DATA]};
            end
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 10'd1;
        end
    end

    always_ff @(posedge clock_27mhz) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            sel_rs_q       <= 1'b0;
            cnt_q          <= '0;
            dot_sr_q       <= '0;
            ctrl_sr_q      <= '0;
            dot_reg_q      <= '0;
            control_word_q <= '0;
            dot_strobe_q   <= 1'b0;
            ctrl_strobe_q  <= 1'b0;
            last_count_q   <= '0;
            len_err_q      <= 1'b0;
        end else begin
            dot_strobe_q  <= 1'b0;
            ctrl_strobe_q <= 1'b0;
            if (!sync2_q[S_RSTB]) begin
                // Device reset wipes the control side but the visible dot register survives.
                state_q        <= ST_DEVRST;
                control_word_q <= '0;
                dot_sr_q       <= '0;
                ctrl_sr_q      <= '0;
                cnt_q          <= '0;
            end else begin
                case (state_q)
                    ST_DEVRST: begin
                        state_q <= ST_IDLE;
                    end
                    ST_IDLE: begin
                        if (ce_fall) begin
                            sel_rs_q <= sync2_q[S_RS];
                            cnt_q    <= '0;
                            state_q  <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        dot_sr_q  <= dot_sr_d;
                        ctrl_sr_q <= ctrl_sr_d;
                        cnt_q     <= cnt_d;
                        if (ce_rise) begin
                            if (sel_rs_q) begin
                                control_word_q <= ctrl_sr_d;
                                ctrl_strobe_q  <= 1'b1;
                                len_err_q      <= (cnt_d != CTRL_LEN);
                            end else begin
                                dot_reg_q    <= dot_sr_d;
                                dot_strobe_q <= 1'b1;
                                len_err_q    <= (cnt_d != DOT_LEN);
                            end
                            last_count_q <= cnt_d;
                            state_q      <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock_27mhz) begin
        if (reset) begin
            rd_dots_q <= '0;
        end else begin
            rd_dots_q <= dot_reg_q[DOTS_PER_CHAR*int'(rd_char) +: DOTS_PER_CHAR];
        end
    end

    assign rd_dots      = rd_dots_q;
    assign control_word = control_word_q;
    assign dot_strobe   = dot_strobe_q;
    assign ctrl_strobe  = ctrl_strobe_q;
    assign last_count   = last_count_q;
    assign len_err      = len_err_q;
    assign blanked      = sync2_q[S_BLANK];
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_hex_display_link_receiver.sv
// Directed bench for hex_display_link_receiver: drives the serial display lines and
// compares the rebuilt registers against a bit-history model of the daisy chain.
module tb_hex_display_link_receiver;

    localparam int HALF = 14;
    localparam logic [39:0] GLYPH_F = 40'b01111111_00001001_00001001_00001001_00000001;
    localparam logic [39:0] GLYPH_8 = 40'b00000000_11111111_00001010_00001100_00001000;

    logic        clk;
    logic        reset;
    logic        disp_clock;
    logic        disp_data_out;
    logic        disp_rs;
    logic        disp_ce_b;
    logic        disp_reset_b;
    logic        disp_blank;
    logic [3:0]  rd_char;
    logic [39:0] rd_dots;
    logic [31:0] control_word;
    logic        dot_strobe;
    logic        ctrl_strobe;
    logic [9:0]  last_count;
    logic        len_err;
    logic        blanked;
    logic [1:0]  dbg_state;

    hex_display_link_receiver dut (
        .clock_27mhz  (clk),
        .reset        (reset),
        .disp_clock   (disp_clock),
        .disp_data_out(disp_data_out),
        .disp_rs      (disp_rs),
        .disp_ce_b    (disp_ce_b),
        .disp_reset_b (disp_reset_b),
        .disp_blank   (disp_blank),
        .rd_char      (rd_char),
        .rd_dots      (rd_dots),
        .control_word (control_word),
        .dot_strobe   (dot_strobe),
        .ctrl_strobe  (ctrl_strobe),
        .last_count   (last_count),
        .len_err      (len_err),
        .blanked      (blanked),
        .dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: the chain is the most recent bits shifted in on each register select.
    bit          dot_hist[$];
    bit          ctrl_hist[$];
    logic [639:0] m_dot_reg = '0;
    logic [31:0]  m_ctrl_word = '0;
    logic [9:0]   m_last_count = '0;
    logic         m_len_err = 1'b0;
    logic         m_blank = 1'b0;
    int           m_dot_strobes = 0;
    int           m_ctrl_strobes = 0;
    int           dot_seen = 0;
    int           ctrl_seen = 0;
    logic         win_open = 1'b0;
    logic         win_sel = 1'b0;
    int           win_cnt = 0;
    logic         chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (dot_strobe) dot_seen++;
        if (ctrl_strobe) ctrl_seen++;
        if (chk_en) begin
            check("control_word", control_word, m_ctrl_word);
            check("last_count", last_count, m_last_count);
            check("len_err", len_err, m_len_err);
            check("blanked", blanked, m_blank);
            check("rd_dots", rd_dots, m_dot_reg[40*rd_char +: 40]);
            check("strobes_quiet", {dot_strobe, ctrl_strobe}, 2'b00);
        end
    end

    function automatic logic [39:0] glyph(input logic [3:0] n);
        logic [39:0] g;
        case (n)
            4'hF:    g = GLYPH_F;
            4'h8:    g = GLYPH_8;
            default: g = {5{n, ~n}};
        endcase
        return g;
    endfunction

    function automatic logic [639:0] build_dot();
        logic [639:0] v;
        int n;
        v = '0;
        n = dot_hist.size();
        for (int i = 0; i < n; i++) v[i] = dot_hist[n-1-i];
        return v;
    endfunction

    function automatic logic [31:0] build_ctrl();
        logic [31:0] v;
        int n;
        v = '0;
        n = ctrl_hist.size();
        for (int i = 0; i < n; i++) v[i] = ctrl_hist[n-1-i];
        return v;
    endfunction

    task automatic push_bit(input logic b);
        if (win_open) begin
            if (win_sel) begin
                ctrl_hist.push_back(b);
                if (ctrl_hist.size() > 32) void'(ctrl_hist.pop_front());
            end else begin
                dot_hist.push_back(b);
                if (dot_hist.size() > 640) void'(dot_hist.pop_front());
            end
            if (win_cnt < 1023) win_cnt++;
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk) disp_data_out = b;
        repeat (HALF) @(negedge clk);
        disp_clock = 1'b1;
        push_bit(b);
        repeat (HALF) @(negedge clk);
        disp_clock = 1'b0;
    endtask

    task automatic send_word32(input logic [31:0] w, input int from_bit, input int to_bit);
        for (int b = from_bit; b >= to_bit; b--) send_bit(w[b]);
    endtask

    task automatic send_dots(input logic [63:0] data);
        logic [39:0] g;
        for (int c = 15; c >= 0; c--) begin
            g = glyph(data[4*c +: 4]);
            for (int b = 39; b >= 0; b--) send_bit(g[b]);
        end
    endtask

    task automatic ce_fall(input logic rs);
        @(negedge clk) chk_en = 1'b0;
        disp_rs = rs;
        repeat (4) @(negedge clk);
        disp_ce_b = 1'b0;
        win_open = 1'b1;
        win_sel = rs;
        win_cnt = 0;
        repeat (6) @(negedge clk);
    endtask

    task automatic finish_window();
        repeat (8) @(negedge clk);
        if (win_sel) begin
            m_ctrl_word = build_ctrl();
            m_ctrl_strobes++;
            m_len_err = (win_cnt != 32);
        end else begin
            m_dot_reg = build_dot();
            m_dot_strobes++;
            m_len_err = (win_cnt != 640);
        end
        m_last_count = 10'(win_cnt);
        win_open = 1'b0;
        check("dot_strobe_count", dot_seen, m_dot_strobes);
        check("ctrl_strobe_count", ctrl_seen, m_ctrl_strobes);
        chk_en = 1'b1;
    endtask

    task automatic ce_rise(input logic new_rs);
        @(negedge clk) disp_ce_b = 1'b1;
        disp_rs = new_rs;
        finish_window();
    endtask

    // Last bit's clock rise lands in the same cycle as the CE rise and an RS change.
    task automatic end_with_bit(input logic b, input logic new_rs);
        @(negedge clk) disp_data_out = b;
        repeat (HALF) @(negedge clk);
        disp_clock = 1'b1;
        disp_ce_b = 1'b1;
        disp_rs = new_rs;
        push_bit(b);
        repeat (HALF) @(negedge clk);
        disp_clock = 1'b0;
        finish_window();
    endtask

    task automatic sweep_rd();
        for (int c = 0; c < 16; c++) begin
            @(negedge clk) rd_char = 4'(c);
            @(negedge clk);
            check("rd_sweep", rd_dots, m_dot_reg[40*c +: 40]);
        end
    endtask

    task automatic read_char(input logic [3:0] c);
        @(negedge clk) rd_char = c;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset_check();
        @(negedge clk) chk_en = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_control_word", control_word, 32'h0);
        check("rst_rd_dots", rd_dots, 40'h0);
        check("rst_strobes", {dot_strobe, ctrl_strobe}, 2'b00);
        check("rst_last_count", last_count, 10'h0);
        check("rst_len_err", len_err, 1'b0);
        check("rst_blanked", blanked, 1'b0);
        check("rst_state", dbg_state, 2'd0);
        @(negedge clk) reset = 1'b0;
        dot_hist.delete();
        ctrl_hist.delete();
        m_dot_reg = '0;
        m_ctrl_word = '0;
        m_last_count = '0;
        m_len_err = 1'b0;
        m_blank = disp_blank;
        win_open = 1'b0;
        repeat (8) @(negedge clk);
        chk_en = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        disp_clock = 1'b0;
        disp_data_out = 1'b0;
        disp_rs = 1'b0;
        disp_ce_b = 1'b1;
        disp_reset_b = 1'b1;
        disp_blank = 1'b0;
        rd_char = 4'd0;

        do_reset_check();
        sweep_rd();

        @(negedge clk) chk_en = 1'b0;
        disp_blank = 1'b1;
        repeat (5) @(negedge clk);
        m_blank = 1'b1;
        chk_en = 1'b1;
        repeat (5) @(negedge clk);
        chk_en = 1'b0;
        disp_blank = 1'b0;
        repeat (5) @(negedge clk);
        m_blank = 1'b0;
        chk_en = 1'b1;

        ce_fall(1'b1);
        send_word32(32'h7F7F7F7F, 31, 0);
        ce_rise(1'b1);
        check("ctrl_word_lit", control_word, 32'h7F7F7F7F);
        check("ctrl_count_lit", last_count, 10'd32);
        check("ctrl_len_err_lit", len_err, 1'b0);

        ce_fall(1'b0);
        send_dots(64'h0123456789ABCDEF);
        ce_rise(1'b0);
        read_char(4'd0);
        check("dots_char0_lit", rd_dots, GLYPH_F);
        read_char(4'd7);
        check("dots_char7_lit", rd_dots, GLYPH_8);
        check("dot_count_lit", last_count, 10'd640);
        check("dot_len_err_lit", len_err, 1'b0);
        sweep_rd();

        ce_fall(1'b0);
        for (int i = 0; i < 600; i++) send_bit(i % 3 == 0);
        ce_rise(1'b0);
        check("short_count_lit", last_count, 10'd600);
        check("short_len_err_lit", len_err, 1'b1);
        read_char(4'd15);
        check("short_char15_lit", rd_dots, GLYPH_F);
        sweep_rd();

        ce_fall(1'b1);
        send_word32(32'hA5C30F96, 31, 12);
        @(negedge clk) disp_rs = 1'b0;
        send_word32(32'hA5C30F96, 11, 1);
        end_with_bit(1'b0, 1'b0);
        check("race_ctrl_lit", control_word, 32'hA5C30F96);
        check("race_ctrl_count_lit", last_count, 10'd32);

        for (int i = 0; i < 3; i++) send_bit(1'b1);

        ce_fall(1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        @(negedge clk) disp_rs = 1'b1;
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        @(negedge clk) disp_rs = 1'b0;
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        ce_rise(1'b1);
        check("race_dot_count_lit", last_count, 10'd16);
        check("race_dot_len_err_lit", len_err, 1'b1);
        check("race_ctrl_kept_lit", control_word, 32'hA5C30F96);
        sweep_rd();

        ce_fall(1'b0);
        for (int i = 0; i < 100; i++) send_bit(i[0]);
        @(negedge clk) disp_reset_b = 1'b0;
        repeat (10) @(negedge clk);
        disp_ce_b = 1'b1;
        win_open = 1'b0;
        repeat (5) @(negedge clk);
        disp_reset_b = 1'b1;
        repeat (8) @(negedge clk);
        dot_hist.delete();
        ctrl_hist.delete();
        m_ctrl_word = '0;
        check("devrst_dot_strobes", dot_seen, m_dot_strobes);
        check("devrst_ctrl_strobes", ctrl_seen, m_ctrl_strobes);
        check("devrst_ctrl_lit", control_word, 32'h0);
        check("devrst_count_kept_lit", last_count, 10'd16);
        chk_en = 1'b1;
        sweep_rd();

        ce_fall(1'b0);
        send_dots(64'hFEDCBA9876543210);
        ce_rise(1'b0);
        check("reload_count_lit", last_count, 10'd640);
        check("reload_len_err_lit", len_err, 1'b0);
        read_char(4'd15);
        check("reload_char15_lit", rd_dots, GLYPH_F);
        read_char(4'd8);
        check("reload_char8_lit", rd_dots, GLYPH_8);
        sweep_rd();

        @(negedge clk) chk_en = 1'b0;
        disp_blank = 1'b1;
        repeat (5) @(negedge clk);
        do_reset_check();
        sweep_rd();
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
